md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit in the execute stage, directly downstream of the decode stage and the ID/EX register. It consumes the forwarded rs/rt operands and the decoded mult/div operation, models MIPS MULT/MULTU/DIV/DIVU latency with a busy counter, and holds the architectural HI/LO registers. The hazard unit stalls decode on `md_stall`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD/MADDU); must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; must be ≥1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  op valid in E this cycle.
- `op`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; others NONE.
- `rs_val`  in  32  operand A / MTHI / MTLO source.
- `rt_val`  in  32  operand B.
- `busy`  out  1  operation in flight.
- `md_stall`  out  1  combinational: `busy | (start & op ∈ {1,2,3,4,7,8 as enabled})`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN. Reset → IDLE, `busy`=0, `hi`=`lo`=0, counter=0.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU (or MADD/MADDU when enabled): latch `rs_val`, `rt_val`, op; load counter with N (MULT_CYCLES or DIV_CYCLES); → RUN.
- IDLE, `start`=1, op MTHI/MTLO: write `hi`/`lo` = `rs_val` at that edge; stay IDLE; `busy` stays 0.
- RUN: counter decrements each edge; on the edge where it reaches 0, commit result to `hi`/`lo` and → IDLE.
- `start` while `busy`=1: ignored entirely, including MTHI/MTLO; the hazard unit must not issue.
- MULT: `{hi,lo}` = signed 32×32 → 64. MULTU: unsigned.
- DIV: `lo`=signed quotient (truncate toward zero), `hi`=remainder with sign of dividend. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Divide by zero (DIV/DIVU): run the full DIV_CYCLES, then leave `hi`/`lo` unchanged.
- Result computed from latched operands only; changes on `rs_val`/`rt_val` during RUN have no effect.
- `hi`/`lo` hold old values throughout RUN. Readers (MFHI/MFLO) are stalled by `md_stall`.

## Timing
- `start` sampled at edge T: `busy`=1 after T through edge T+N−1; at edge T+N, `busy`→0 and new `hi`/`lo` visible. For N=5, `busy` is high for exactly 5 cycles.
- A new `start` is accepted in the same cycle `busy` first reads 0, back-to-back with no gap cycle.
- MTHI/MTLO: visible one edge after `start`.
- `md_stall` is high in the issuing cycle itself (before `busy` rises) and in every RUN cycle. It is low in the cycle after the commit edge.
- Reset asserted mid-RUN: immediately IDLE, `busy`=0, `hi`=`lo`=0; pending result discarded; no commit after release.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Configuration
- `MD_MADD_EN` defined: ops 7/8 accepted. At commit, `{hi,lo}` += signed (MADD) or unsigned (MADDU) 64-bit product, modulo 2^64. The addend is the `{hi,lo}` value at commit time; latency is MULT_CYCLES.
- `MD_MADD_EN` undefined: ops 7/8 decode as NONE. No busy, no state change, and not counted in `md_stall`.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (−2), rt=3 → `busy` high 5 cycles. Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. Repeat as MULTU → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- MTHI 0x12345678, then DIVU rs=5, rt=0 → `busy` 10 cycles; `hi` stays 0x12345678 and `lo` unchanged. Issue MTLO during `busy` → ignored.
- MULT started, then `rs_val`/`rt_val` changed and a second `start` asserted during RUN → result reflects the original operands; the second op is dropped. Back-to-back MULT in the first non-busy cycle → accepted.
- Reset pulsed low at cycle 3 of DIV → `busy`=0 and `hi`=`lo`=0 immediately; no commit at the original cycle 10.
- With `MD_MADD_EN`: MTHI 0, MTLO 0xFFFFFFFF, then MADDU rs=1, rt=1 → `hi`=1, `lo`=0. Without the macro: same stimulus → `busy` stays 0, `hi`/`lo` unchanged.

Source files
------------

// File: rtl/md_unit_if.sv
// md_unit_if -- issue/result bundle between the execute stage and md_unit.
//   start/op/rs_val/rt_val : issue side (master drives)
//   busy/md_stall/hi/lo    : unit status and HI/LO registers (slave drives)
interface md_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_val, rt_val, input busy, md_stall, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, md_stall, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit -- multi-cycle MIPS multiply/divide unit holding HI/LO.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   md (slave) : start/op/rs_val/rt_val in; busy/md_stall/hi/lo out
// Ops: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU.
// Optional feature: define MD_MADD_EN to accept MADD/MADDU (accumulate
// into {hi,lo}); otherwise ops 7/8 behave as NONE.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  md_unit_if.slave md
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;

  // Issue decode
  logic is_mul, is_div, is_md;
  always_comb begin
    is_mul = (md.op == OP_MULT) || (md.op == OP_MULTU);
`ifdef MD_MADD_EN
    is_mul = is_mul || (md.op == OP_MADD) || (md.op == OP_MADDU);
`endif
    is_div = (md.op == OP_DIV) || (md.op == OP_DIVU);
    is_md  = is_mul || is_div;
  end

  // Result datapath, driven only by the latched operands
  logic [63:0] prod_s, prod_u, hilo_d;
  logic [31:0] mag_a, mag_b, divisor, quo, rem, quo_res, rem_res;
  logic        div_sgn;
  always_comb begin
    // Sign-extended 64x64 product truncated to 64 bits equals the signed 32x32 product
    prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u  = {32'b0, a_q} * {32'b0, b_q};
    div_sgn = (op_q == OP_DIV);
    mag_a   = (div_sgn && a_q[31]) ? -a_q : a_q;
    mag_b   = (div_sgn && b_q[31]) ? -b_q : b_q;
    // Keep the divider defined on /0; the result is discarded in that case
    divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo     = mag_a / divisor;
    rem     = mag_a % divisor;
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself
    quo_res = (div_sgn && (a_q[31] ^ b_q[31])) ? -quo : quo;
    rem_res = (div_sgn && a_q[31]) ? -rem : rem;
    hilo_d  = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  hilo_d = prod_s;
      OP_MULTU: hilo_d = prod_u;
      OP_DIV, OP_DIVU: if (b_q != 32'd0) hilo_d = {rem_res, quo_res};
`ifdef MD_MADD_EN
      OP_MADD:  hilo_d = {hi_q, lo_q} + prod_s;
      OP_MADDU: hilo_d = {hi_q, lo_q} + prod_u;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.start) begin
            if (is_md) begin
              a_q     <= md.rs_val;
              b_q     <= md.rt_val;
              op_q    <= md.op;
              cnt_q   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_q <= RUN;
            end else if (md.op == OP_MTHI) begin
              hi_q <= md.rs_val;
            end else if (md.op == OP_MTLO) begin
              lo_q <= md.rs_val;
            end
          end
        end
        RUN: begin
          // Any start while running is dropped; the hazard unit holds issue off.
          if (cnt_q == CNT_W'(1)) begin
            cnt_q        <= '0;
            state_q      <= IDLE;
            {hi_q, lo_q} <= hilo_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic busy;
  assign busy        = (state_q == RUN);
  assign md.busy     = busy;
  assign md.md_stall = busy | (md.start & is_md);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- table-driven bench for md_unit with a hi/lo scoreboard,
// plus hand sequences for in-flight interference, back-to-back issue and
// reset during a divide.
module tb_md_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_unit_if mdi();
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(rst_n), .md(mdi));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input int n, input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.n = n; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Count negedges with busy high; returns at the first negedge where busy is low.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (mdi.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic pop_chk(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_hi"}, mdi.hi, e.hi);
      chk({nm, "_lo"}, mdi.lo, e.lo);
    end
  endtask

  initial begin
    int cyc;
    int bad;
    exp_t e;

    mdi.start = 1'b0; mdi.op = 4'd0; mdi.rs_val = '0; mdi.rt_val = '0;

    vt.push_back(mk(4'd0, 32'h0000AAAA, 32'd0,        0,  32'h00000000, 32'h00000000));
    vt.push_back(mk(4'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA));
    vt.push_back(mk(4'd2, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA));
    vt.push_back(mk(4'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD));
    vt.push_back(mk(4'd4, 32'd7,        32'd2,        10, 32'h00000001, 32'h00000003));
    vt.push_back(mk(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000));
    vt.push_back(mk(4'd5, 32'h12345678, 32'd0,        0,  32'h12345678, 32'h80000000));
    vt.push_back(mk(4'd4, 32'd5,        32'd0,        10, 32'h12345678, 32'h80000000));
    vt.push_back(mk(4'd6, 32'h0000BEEF, 32'd0,        0,  32'h12345678, 32'h0000BEEF));
    vt.push_back(mk(4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001));
    vt.push_back(mk(4'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD));
    vt.push_back(mk(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001));
    vt.push_back(mk(4'd9, 32'd5,        32'd5,        0,  32'hFFFFFFFE, 32'h00000001));
    vt.push_back(mk(4'd3, 32'hFFFFFFF9, 32'd0,        10, 32'hFFFFFFFE, 32'h00000001));
    vt.push_back(mk(4'd5, 32'd0,        32'd0,        0,  32'h00000000, 32'h00000001));
    vt.push_back(mk(4'd6, 32'hFFFFFFFF, 32'd0,        0,  32'h00000000, 32'hFFFFFFFF));
`ifdef MD_MADD_EN
    vt.push_back(mk(4'd8, 32'd1,        32'd1,        5,  32'h00000001, 32'h00000000));
    vt.push_back(mk(4'd7, 32'hFFFFFFFF, 32'd1,        5,  32'h00000000, 32'hFFFFFFFF));
`else
    vt.push_back(mk(4'd8, 32'd1,        32'd1,        0,  32'h00000000, 32'hFFFFFFFF));
    vt.push_back(mk(4'd7, 32'hFFFFFFFF, 32'd1,        0,  32'h00000000, 32'hFFFFFFFF));
`endif

    // Reset state
    #2;
    chk("rst_busy",  {31'b0, mdi.busy}, 32'd0);
    chk("rst_stall", {31'b0, mdi.md_stall}, 32'd0);
    chk("rst_hi",    mdi.hi, 32'd0);
    chk("rst_lo",    mdi.lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      mdi.start = 1'b1; mdi.op = vt[i].op; mdi.rs_val = vt[i].rs; mdi.rt_val = vt[i].rt;
      #1;
      chk($sformatf("v%0d_stall_issue", i), {31'b0, mdi.md_stall}, (vt[i].n > 0) ? 32'd1 : 32'd0);
      e.hi = vt[i].hi; e.lo = vt[i].lo;
      sb.push_back(e);
      @(posedge clk); #1;
      mdi.start = 1'b0; mdi.op = 4'd0;
      wait_idle(cyc);
      chk($sformatf("v%0d_busy_cycles", i), 32'(cyc), 32'(vt[i].n));
      chk($sformatf("v%0d_stall_after", i), {31'b0, mdi.md_stall}, 32'd0);
      pop_chk($sformatf("v%0d", i));
    end

    // MULT, then operand change + second MULT + MTLO while running; all dropped
    @(negedge clk);
    mdi.start = 1'b1; mdi.op = 4'd1; mdi.rs_val = 32'd3; mdi.rt_val = 32'd4;
    e.hi = 32'd0; e.lo = 32'd12; sb.push_back(e);
    @(posedge clk); #1;
    mdi.rs_val = 32'd100; mdi.rt_val = 32'd100;
    @(negedge clk);
    chk("ovl_busy1",  {31'b0, mdi.busy}, 32'd1);
    chk("ovl_stall1", {31'b0, mdi.md_stall}, 32'd1);
    @(posedge clk); #1;
    mdi.op = 4'd6; mdi.rs_val = 32'hDEAD;
    @(negedge clk);
    chk("ovl_busy2", {31'b0, mdi.busy}, 32'd1);
    @(posedge clk); #1;
    mdi.start = 1'b0; mdi.op = 4'd0;
    wait_idle(cyc);
    chk("ovl_busy_cycles", 32'(cyc + 2), 32'd5);
    chk("ovl_stall_after", {31'b0, mdi.md_stall}, 32'd0);
    pop_chk("ovl");

    // Back-to-back: issue in the first cycle busy reads low
    mdi.start = 1'b1; mdi.op = 4'd1; mdi.rs_val = 32'd5; mdi.rt_val = 32'd6;
    e.hi = 32'd0; e.lo = 32'd30; sb.push_back(e);
    @(posedge clk); #1;
    mdi.start = 1'b0; mdi.op = 4'd0;
    wait_idle(cyc);
    chk("b2b_busy_cycles", 32'(cyc), 32'd5);
    pop_chk("b2b");

    // Reset during a DIV: cleared immediately, no late commit
    @(negedge clk);
    mdi.start = 1'b1; mdi.op = 4'd3; mdi.rs_val = 32'd100; mdi.rt_val = 32'd7;
    @(posedge clk); #1;
    mdi.start = 1'b0; mdi.op = 4'd0;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", {31'b0, mdi.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'b0, mdi.busy}, 32'd0);
    chk("mid_hi",   mdi.hi, 32'd0);
    chk("mid_lo",   mdi.lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (mdi.busy || mdi.hi != 32'd0 || mdi.lo != 32'd0) bad++;
    end
    chk("mid_no_commit", 32'(bad), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
